// File: rtl/adc_spi_responder.sv
// MCP3002-compatible SPI device model: oversamples CS/SCK/SDI in the sysclk domain
// and shifts out a snapshot of ch0/ch1 (or their clamped difference) per frame.
module adc_spi_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_SDO    = 1'b0
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       adc_cs,
  input  logic       adc_sck,
  input  logic       sdata_to_adc,
  output logic       sdata_from_adc,
  output logic       sdo_en,
  input  logic [9:0] ch0_value,
  input  logic [9:0] ch1_value,
  output logic       conv_done,
  output logic       frame_error,
  output logic       last_channel,
  output logic       last_sgl
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_CFG        = 3'd2;
  localparam logic [2:0] S_NULL_BIT   = 3'd3;
  localparam logic [2:0] S_DATA       = 3'd4;
  localparam logic [2:0] S_TAIL       = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_sdi_sync;
  logic       w_cs, w_sck, w_sdi;
  logic       r_cs_prev, r_sck_prev;
  logic       r_cs_rise, r_cs_fall, r_sck_rise, r_sck_fall, r_sdi;
  logic [2:0] r_state;
  logic [1:0] r_bit_cnt;
  logic [3:0] r_idx;
  logic       r_sgl, r_odd, r_msbf;
  logic [9:0] r_result;
  logic       r_sdo, r_sdo_en, r_conv_done, r_frame_error, r_last_channel, r_last_sgl;
  logic [10:0] w_diff;
  logic [9:0]  w_snap;

  assign w_cs  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  // Edge pulses are registered so they line up with the registered SDI sample.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_cs_sync  <= '1;
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_prev  <= 1'b1;
      r_sck_prev <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_sdi      <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], adc_sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdata_to_adc};
      r_cs_prev  <= w_cs;
      r_sck_prev <= w_sck;
      r_cs_rise  <= w_cs & ~r_cs_prev;
      r_cs_fall  <= ~w_cs & r_cs_prev;
      r_sck_rise <= w_sck & ~r_sck_prev;
      r_sck_fall <= ~w_sck & r_sck_prev;
      r_sdi      <= w_sdi;
    end
  end

  // Pseudo-differential result: 11-bit subtraction, negative clamps to zero.
  always_comb begin
    w_diff = r_odd ? ({1'b0, ch1_value} - {1'b0, ch0_value})
                   : ({1'b0, ch0_value} - {1'b0, ch1_value});
    if (r_sgl)
      w_snap = r_odd ? ch1_value : ch0_value;
    else if (w_diff[10])
      w_snap = '0;
    else
      w_snap = w_diff[9:0];
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= 2'd0;
      r_idx          <= 4'd0;
      r_sgl          <= 1'b0;
      r_odd          <= 1'b0;
      r_msbf         <= 1'b0;
      r_result       <= '0;
      r_sdo          <= IDLE_SDO;
      r_sdo_en       <= 1'b0;
      r_conv_done    <= 1'b0;
      r_frame_error  <= 1'b0;
      r_last_channel <= 1'b0;
      r_last_sgl     <= 1'b0;
    end else begin
      r_conv_done   <= 1'b0;
      r_frame_error <= 1'b0;
      if (r_cs_rise && r_state != S_IDLE) begin
        r_state  <= S_IDLE;
        r_sdo_en <= 1'b0;
        r_sdo    <= IDLE_SDO;
        if (r_state == S_DONE) begin
          r_conv_done    <= 1'b1;
          r_last_channel <= r_odd;
          r_last_sgl     <= r_sgl;
        end else if (r_state != S_WAIT_START) begin
          r_frame_error <= 1'b1;
        end
      end else if (r_cs_fall) begin
        r_state  <= S_WAIT_START;
        r_sdo_en <= 1'b0;
        r_sdo    <= IDLE_SDO;
      end else if (!r_cs_prev) begin
        case (r_state)
          S_WAIT_START: begin
            if (r_sck_rise && r_sdi) begin
              r_state   <= S_CFG;
              r_bit_cnt <= 2'd0;
            end
          end
          S_CFG: begin
            if (r_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 2'd1;
              case (r_bit_cnt)
                2'd0: r_sgl <= r_sdi;
                2'd1: r_odd <= r_sdi;
                default: begin
                  r_msbf   <= r_sdi;
                  r_result <= w_snap;
                  r_state  <= S_NULL_BIT;
                end
              endcase
            end
          end
          S_NULL_BIT: begin
            if (r_sck_fall) begin
              r_sdo    <= 1'b0;
              r_sdo_en <= 1'b1;
              r_idx    <= 4'd9;
              r_state  <= S_DATA;
            end
          end
          S_DATA: begin
            if (r_sck_fall) begin
              r_sdo <= r_result[r_idx];
              if (r_idx == 4'd0) begin
                r_idx   <= 4'd1;
                r_state <= r_msbf ? S_DONE : S_TAIL;
              end else begin
                r_idx <= r_idx - 4'd1;
              end
            end
          end
          S_TAIL: begin
            if (r_sck_fall) begin
              r_sdo <= r_result[r_idx];
              if (r_idx == 4'd9)
                r_state <= S_DONE;
              else
                r_idx <= r_idx + 4'd1;
            end
          end
          S_DONE: begin
            if (r_sck_fall)
              r_sdo <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sdata_from_adc = r_sdo;
  assign sdo_en         = r_sdo_en;
  assign conv_done      = r_conv_done;
  assign frame_error    = r_frame_error;
  assign last_channel   = r_last_channel;
  assign last_sgl       = r_last_sgl;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives MCP3002-style frames, predicts every sampled
// SDO bit into a queue and checks it at the initiator's rising SCK edge.
module tb_adc_spi_responder;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       adc_cs = 1'b1;
  logic       adc_sck = 1'b0;
  logic       sdata_to_adc = 1'b0;
  logic [9:0] ch0_value = '0;
  logic [9:0] ch1_value = '0;
  logic       sdata_from_adc, sdo_en, conv_done, frame_error, last_channel, last_sgl;

  int checks = 0;
  int failures = 0;
  int n_conv = 0;
  int n_ferr = 0;

  typedef struct packed {
    logic en;
    logic sdo;
  } sample_t;
  sample_t exp_q[$];

  adc_spi_responder #(.SYNC_STAGES(2), .IDLE_SDO(1'b0)) dut (
    .sysclk(sysclk), .reset(reset), .adc_cs(adc_cs), .adc_sck(adc_sck),
    .sdata_to_adc(sdata_to_adc), .sdata_from_adc(sdata_from_adc), .sdo_en(sdo_en),
    .ch0_value(ch0_value), .ch1_value(ch1_value), .conv_done(conv_done),
    .frame_error(frame_error), .last_channel(last_channel), .last_sgl(last_sgl)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (conv_done)   n_conv <= n_conv + 1;
    if (frame_error) n_ferr <= n_ferr + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    checks++; if (sdo_en !== 1'b0) begin failures++; $display("FAIL reset_sdo_en got=%b exp=0", sdo_en); end
    checks++; if (sdata_from_adc !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b exp=0", sdata_from_adc); end
    checks++; if (conv_done !== 1'b0) begin failures++; $display("FAIL reset_conv_done got=%b exp=0", conv_done); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    checks++; if (last_channel !== 1'b0) begin failures++; $display("FAIL reset_last_channel got=%b exp=0", last_channel); end
    checks++; if (last_sgl !== 1'b0) begin failures++; $display("FAIL reset_last_sgl got=%b exp=0", last_sgl); end
    reset = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  // One CS frame of n_sck clocks; optionally changes ch0 right after the 5th rising edge.
  task automatic run_frame(input string name, input logic sgl, input logic odd, input logic msbf,
                           input int n_sck, input logic do_chg, input logic [9:0] chg_val,
                           input logic expect_done);
    int       diff;
    logic [9:0] res;
    sample_t  s, got;
    int       c0, f0;
    logic     lc0, ls0, bit_k;
    if (sgl) res = odd ? ch1_value : ch0_value;
    else begin
      diff = odd ? (int'(ch1_value) - int'(ch0_value)) : (int'(ch0_value) - int'(ch1_value));
      if (diff < 0) diff = 0;
      res = diff[9:0];
    end
    exp_q.delete();
    for (int k = 1; k <= n_sck; k++) begin
      if (k <= 4)                       s = '{en: 1'b0, sdo: 1'b0};
      else if (k == 5)                  s = '{en: 1'b1, sdo: 1'b0};
      else if (k <= 15)                 s = '{en: 1'b1, sdo: res[15-k]};
      else if (!msbf && k <= 24)        s = '{en: 1'b1, sdo: res[k-15]};
      else                              s = '{en: 1'b1, sdo: 1'b0};
      exp_q.push_back(s);
    end
    adc_cs = 1'b0;
    repeat (8) @(negedge sysclk);
    for (int k = 1; k <= n_sck; k++) begin
      case (k)
        1: bit_k = 1'b1;
        2: bit_k = sgl;
        3: bit_k = odd;
        4: bit_k = msbf;
        default: bit_k = 1'b0;
      endcase
      sdata_to_adc = bit_k;
      repeat (8) @(negedge sysclk);
      got = '{en: sdo_en, sdo: sdata_from_adc};
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL %s_queue rise=%0d got=empty exp=entry", name, k);
      end else begin
        s = exp_q.pop_front();
        if (got !== s) begin
          failures++;
          $display("FAIL %s_bit rise=%0d got en=%b sdo=%b exp en=%b sdo=%b", name, k, got.en, got.sdo, s.en, s.sdo);
        end
      end
      adc_sck = 1'b1;
      if (do_chg && k == 5) ch0_value = chg_val;
      repeat (8) @(negedge sysclk);
      adc_sck = 1'b0;
    end
    repeat (8) @(negedge sysclk);
    c0 = n_conv; f0 = n_ferr; lc0 = last_channel; ls0 = last_sgl;
    adc_cs = 1'b1;
    sdata_to_adc = 1'b0;
    repeat (20) @(negedge sysclk);
    checks++; if (sdo_en !== 1'b0) begin failures++; $display("FAIL %s_end_sdo_en got=%b exp=0", name, sdo_en); end
    checks++; if (sdata_from_adc !== 1'b0) begin failures++; $display("FAIL %s_end_sdo got=%b exp=0", name, sdata_from_adc); end
    checks++;
    if ((n_conv - c0) !== (expect_done ? 1 : 0)) begin
      failures++; $display("FAIL %s_conv_done got=%0d exp=%0d", name, n_conv - c0, expect_done ? 1 : 0);
    end
    checks++;
    if ((n_ferr - f0) !== (expect_done ? 0 : 1)) begin
      failures++; $display("FAIL %s_frame_error got=%0d exp=%0d", name, n_ferr - f0, expect_done ? 0 : 1);
    end
    checks++;
    if (last_channel !== (expect_done ? odd : lc0)) begin
      failures++; $display("FAIL %s_last_channel got=%b exp=%b", name, last_channel, expect_done ? odd : lc0);
    end
    checks++;
    if (last_sgl !== (expect_done ? sgl : ls0)) begin
      failures++; $display("FAIL %s_last_sgl got=%b exp=%b", name, last_sgl, expect_done ? sgl : ls0);
    end
    $display("frame %s sgl=%b odd=%b msbf=%b sck=%0d result=%03h", name, sgl, odd, msbf, n_sck, res);
  endtask

  task automatic test_single_ended();
    ch0_value = 10'h2A5; ch1_value = 10'h155;
    run_frame("sgl_ch0", 1'b1, 1'b0, 1'b1, 16, 1'b0, 10'h0, 1'b1);
    ch0_value = 10'h000; ch1_value = 10'h3FF;
    run_frame("sgl_ch1", 1'b1, 1'b1, 1'b1, 16, 1'b0, 10'h0, 1'b1);
  endtask

  task automatic test_lsb_first();
    ch0_value = 10'h001; ch1_value = 10'h2F0;
    run_frame("lsb_first", 1'b1, 1'b0, 1'b0, 26, 1'b0, 10'h0, 1'b1);
  endtask

  task automatic test_differential();
    ch0_value = 10'h100; ch1_value = 10'h180;
    run_frame("diff_clamp", 1'b0, 1'b0, 1'b1, 16, 1'b0, 10'h0, 1'b1);
    run_frame("diff_pos", 1'b0, 1'b1, 1'b1, 16, 1'b0, 10'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    ch0_value = 10'h0F3; ch1_value = 10'h000;
    run_frame("abort", 1'b1, 1'b0, 1'b1, 6, 1'b0, 10'h0, 1'b0);
    ch0_value = 10'h155;
    run_frame("chg_mid", 1'b1, 1'b0, 1'b1, 16, 1'b1, 10'h0AA, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    logic [4:0] cfg;
    ch0_value = 10'h2A5;
    cfg = 5'b11001;
    adc_cs = 1'b0;
    repeat (8) @(negedge sysclk);
    for (int k = 1; k <= 8; k++) begin
      sdata_to_adc = (k <= 4) ? cfg[5-k] : 1'b0;
      repeat (8) @(negedge sysclk);
      adc_sck = 1'b1;
      repeat (8) @(negedge sysclk);
      adc_sck = 1'b0;
    end
    repeat (2) @(negedge sysclk);
    f0 = n_ferr;
    reset = 1'b1; adc_cs = 1'b1; adc_sck = 1'b0; sdata_to_adc = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
    checks++; if (sdo_en !== 1'b0) begin failures++; $display("FAIL rst_mid_sdo_en got=%b exp=0", sdo_en); end
    checks++; if (sdata_from_adc !== 1'b0) begin failures++; $display("FAIL rst_mid_sdo got=%b exp=0", sdata_from_adc); end
    checks++; if (conv_done !== 1'b0) begin failures++; $display("FAIL rst_mid_conv_done got=%b exp=0", conv_done); end
    checks++; if (last_channel !== 1'b0) begin failures++; $display("FAIL rst_mid_last_channel got=%b exp=0", last_channel); end
    checks++; if (last_sgl !== 1'b0) begin failures++; $display("FAIL rst_mid_last_sgl got=%b exp=0", last_sgl); end
    repeat (20) @(negedge sysclk);
    checks++; if (n_ferr !== f0) begin failures++; $display("FAIL rst_mid_no_error got=%0d exp=%0d", n_ferr, f0); end
    $display("frame rst_mid reset applied during data phase");
    ch0_value = 10'h2A5;
    run_frame("after_reset", 1'b1, 1'b0, 1'b1, 16, 1'b0, 10'h0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_ended();
    test_lsb_first();
    test_differential();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
